// File: rtl/sqrt_core_arbiter.sv
// Round-robin arbiter sharing a single core_SQRT between two requesters.
// Issues a one-cycle Do pulse, waits for the core (with a timeout), and routes the result back.
module sqrt_core_arbiter #(
  parameter int WIDTH   = 9,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic             req0_op_i,
  input  logic [WIDTH-1:0] req0_s_i,
  output logic             req0_ready_o,
  output logic             rsp0_valid_o,
  output logic [WIDTH-1:0] rsp0_res_o,
  output logic             rsp0_err_o,
  input  logic             req1_valid_i,
  input  logic             req1_op_i,
  input  logic [WIDTH-1:0] req1_s_i,
  output logic             req1_ready_o,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp1_res_o,
  output logic             rsp1_err_o,
  output logic             DoSqrt_o,
  output logic             DoInvSqrt_o,
  output logic [WIDTH-1:0] s_o,
  input  logic [WIDTH-1:0] res_i,
  input  logic             valid_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic             r_gnt_id;
  logic [7:0]       r_cnt;
  logic             r_do_sqrt;
  logic             r_do_inv;
  logic [WIDTH-1:0] r_s;
  logic [1:0]       r_rsp_valid;
  logic [1:0]       r_rsp_err;
  logic [WIDTH-1:0] r_rsp_res0;
  logic [WIDTH-1:0] r_rsp_res1;

  logic             w_gnt_id;
  logic             w_accept;
  logic             w_op;
  logic [WIDTH-1:0] w_s;
  logic             w_timeout;

  // r_rr names the requester that wins when both are valid.
  assign w_gnt_id  = (req0_valid_i & req1_valid_i) ? r_rr : req1_valid_i;
  assign w_accept  = (r_state == S_IDLE) && !rst && (req0_valid_i || req1_valid_i);
  assign w_op      = w_gnt_id ? req1_op_i : req0_op_i;
  assign w_s       = w_gnt_id ? req1_s_i  : req0_s_i;
  assign w_timeout = (r_cnt == LAST_CNT);

  assign req0_ready_o = w_accept & ~w_gnt_id;
  assign req1_ready_o = w_accept &  w_gnt_id;

  // NOTE: the next state defaults to the current one before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (valid_i || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every branch sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_gnt_id    <= 1'b0;
      r_cnt       <= '0;
      r_do_sqrt   <= 1'b0;
      r_do_inv    <= 1'b0;
      r_s         <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_res0  <= '0;
      r_rsp_res1  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_do_sqrt   <= 1'b0;
      r_do_inv    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_res0  <= '0;
      r_rsp_res1  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt_id  <= w_gnt_id;
            r_s       <= w_s;
            r_do_sqrt <= ~w_op;
            r_do_inv  <= w_op;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // A core valid on the last timeout cycle still counts as a real result.
          if (valid_i) begin
            r_rsp_valid[r_gnt_id] <= 1'b1;
            if (r_gnt_id) r_rsp_res1 <= res_i;
            else          r_rsp_res0 <= res_i;
          end else if (w_timeout) begin
            r_rsp_valid[r_gnt_id] <= 1'b1;
            r_rsp_err[r_gnt_id]   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: r_rr <= ~r_gnt_id;
        default: ;
      endcase
    end
  end

  assign DoSqrt_o     = r_do_sqrt;
  assign DoInvSqrt_o  = r_do_inv;
  assign s_o          = r_s;
  assign rsp0_valid_o = r_rsp_valid[0];
  assign rsp1_valid_o = r_rsp_valid[1];
  assign rsp0_err_o   = r_rsp_err[0];
  assign rsp1_err_o   = r_rsp_err[1];
  assign rsp0_res_o   = r_rsp_res0;
  assign rsp1_res_o   = r_rsp_res1;

endmodule

// File: tb/tb_sqrt_core_arbiter.sv
// Scoreboard bench for sqrt_core_arbiter: a driver predicts grants and responses,
// a behavioural core answers Do pulses, and a monitor checks every response pulse.
module tb_sqrt_core_arbiter;

  localparam int WIDTH   = 9;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid_i, req0_op_i, req0_ready_o;
  logic [WIDTH-1:0] req0_s_i;
  logic             rsp0_valid_o, rsp0_err_o;
  logic [WIDTH-1:0] rsp0_res_o;
  logic             req1_valid_i, req1_op_i, req1_ready_o;
  logic [WIDTH-1:0] req1_s_i;
  logic             rsp1_valid_o, rsp1_err_o;
  logic [WIDTH-1:0] rsp1_res_o;
  logic             DoSqrt_o, DoInvSqrt_o;
  logic [WIDTH-1:0] s_o;
  logic [WIDTH-1:0] res_i;
  logic             valid_i;

  sqrt_core_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_op_i(req0_op_i), .req0_s_i(req0_s_i), .req0_ready_o(req0_ready_o),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_res_o(rsp0_res_o), .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_op_i(req1_op_i), .req1_s_i(req1_s_i), .req1_ready_o(req1_ready_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_res_o(rsp1_res_o), .rsp1_err_o(rsp1_err_o),
    .DoSqrt_o(DoSqrt_o), .DoInvSqrt_o(DoInvSqrt_o), .s_o(s_o),
    .res_i(res_i), .valid_i(valid_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit id; logic [WIDTH-1:0] res; bit err; int cyc; } exp_t;
  typedef struct { bit op; logic [WIDTH-1:0] s; int lat; int cyc; } core_t;

  exp_t  exp_q[$];
  core_t core_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    rr_fav = 1'b0;
  int    model_free = 0;
  int    stray_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Toy core function: sqrt returns the operand (sqrt(1.0)=1.0), inverse sqrt its complement.
  function automatic logic [WIDTH-1:0] core_fn(input bit op, input logic [WIDTH-1:0] s);
    return op ? ~s : s;
  endfunction

  // lat = core latency in cycles after the Do pulse; lat <= 0 means the core never answers.
  task automatic do_op(input bit v0, input bit v1, input bit op0, input logic [WIDTH-1:0] s0,
                       input bit op1, input logic [WIDTH-1:0] s1, input int lat);
    int    start, t, n;
    bit    id, op;
    exp_t  e;
    core_t c;
    start = cyc;
    req0_valid_i = v0; req0_op_i = op0; req0_s_i = s0;
    req1_valid_i = v1; req1_op_i = op1; req1_s_i = s1;
    n = 0;
    @(negedge clk);
    while (!(req0_ready_o || req1_ready_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept_seen", {31'd0, (req0_ready_o || req1_ready_o)}, 32'd1);
    end else begin
      t  = cyc;
      id = (v0 && v1) ? rr_fav : v1;
      check("grant", {req1_ready_o, req0_ready_o}, id ? 2'b10 : 2'b01);
      check("accept_cycle", t, (start > model_free) ? start : model_free);
      op = id ? op1 : op0;
      c = '{op: op, s: (id ? s1 : s0), lat: lat, cyc: t + 1};
      core_q.push_back(c);
      e.id  = id;
      e.err = (lat <= 0) || (lat > TIMEOUT);
      e.res = e.err ? '0 : core_fn(op, c.s);
      e.cyc = t + 2 + (e.err ? TIMEOUT : lat);
      exp_q.push_back(e);
      model_free = e.cyc + 1;
      rr_fav = ~id;
    end
    @(posedge clk); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < model_free) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Behavioural core: drives valid_i/res_i for its pending op, or a requested stray pulse.
  int               due = -1;
  logic [WIDTH-1:0] pend_res = '0;

  initial begin
    valid_i = 1'b0;
    res_i   = '0;
    forever begin
      @(posedge clk); #2;
      if (due == cyc) begin
        valid_i = 1'b1;
        res_i   = pend_res;
      end else begin
        valid_i = (stray_cyc == cyc);
        res_i   = WIDTH'($urandom);
      end
    end
  end

  initial begin
    core_t c;
    forever begin
      @(negedge clk);
      if (DoSqrt_o === 1'b1 || DoInvSqrt_o === 1'b1) begin
        check("do_exclusive", {31'd0, DoSqrt_o & DoInvSqrt_o}, 32'd0);
        check("do_expected", {31'd0, core_q.size() != 0}, 32'd1);
        if (core_q.size() != 0) begin
          c = core_q.pop_front();
          check("do_cycle", cyc, c.cyc);
          check("do_op", {31'd0, DoInvSqrt_o}, {31'd0, c.op});
          check("do_operand", s_o, c.s);
          if (c.lat > 0) begin
            due      = cyc + c.lat;
            pend_res = core_fn(DoInvSqrt_o, s_o);
          end
        end
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    bit   id;
    forever begin
      @(negedge clk);
      if (rsp0_valid_o === 1'b1 || rsp1_valid_o === 1'b1) begin
        check("rsp_one_hot", {31'd0, rsp0_valid_o & rsp1_valid_o}, 32'd0);
        id = rsp1_valid_o;
        check("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_port", {31'd0, id}, {31'd0, e.id});
          check("rsp_res", id ? rsp1_res_o : rsp0_res_o, e.res);
          check("rsp_err", {31'd0, id ? rsp1_err_o : rsp0_err_o}, {31'd0, e.err});
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_other_quiet", id ? {rsp0_res_o, rsp0_err_o} : {rsp1_res_o, rsp1_err_o}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, n, lat;
    rst = 1'b1;
    req0_valid_i = 1'b1; req0_op_i = 1'b0; req0_s_i = 9'h100;
    req1_valid_i = 1'b1; req1_op_i = 1'b1; req1_s_i = 9'h080;

    // Reset held two cycles with both requesters valid
    @(posedge clk);
    @(negedge clk);
    check("reset_ready", {req1_ready_o, req0_ready_o}, 32'd0);
    check("reset_core_if", {DoSqrt_o, DoInvSqrt_o, s_o}, 32'd0);
    check("reset_rsp", {rsp0_valid_o, rsp0_res_o, rsp0_err_o, rsp1_valid_o, rsp1_res_o, rsp1_err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_free = cyc;

    // First grant after reset goes to req0; single sqrt of 1.0 with core latency 6
    do_op(1, 1, 0, 9'h100, 1, 9'h080, 6);
    wait_idle();

    // One req1 op so the pointer favours req0 before contention
    do_op(0, 1, 0, 9'h000, 1, 9'h0AA, 2);

    // Contention: both held valid, grants alternate 0,1,0,1 back to back
    for (int i = 0; i < 4; i++) do_op(1, 1, 0, 9'h080, 1, 9'h100, 3 + i);

    // Timeout with a silent core, then a normal op
    do_op(1, 0, 0, 9'h055, 0, 9'h000, 0);
    do_op(0, 1, 0, 9'h000, 1, 9'h123, 4);

    // Valid on the final timeout cycle wins; one cycle later is a timeout
    do_op(1, 0, 1, 9'h1C3, 0, 9'h000, TIMEOUT);
    do_op(1, 0, 0, 9'h0F0, 0, 9'h000, TIMEOUT + 1);

    // Stray core valid while idle produces nothing
    wait_idle();
    stray_cyc = cyc + 1;
    idle_cycles(3);

    // Reset during WAIT; the core answers two cycles after the reset cycle
    do_op(0, 1, 0, 9'h000, 0, 9'h0C0, 6);
    idle_cycles(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    rr_fav = 1'b0;
    model_free = cyc;
    idle_cycles(4);
    do_op(1, 1, 1, 9'h011, 0, 9'h022, 5);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(1, 3);
      lat = $urandom_range(0, 19);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 5));
      do_op(sel[0], sel[1], 1'($urandom), WIDTH'($urandom), 1'($urandom), WIDTH'($urandom), lat);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    idle_cycles(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_core_arbiter.md
Name: sqrt_core_arbiter

Overview:
- Shares one core_SQRT instance (single op in flight, DoSqrt/DoInvSqrt pulse in, res_o/valid_o out) between two requesters.
- Round-robin arbitration; issues the winning op to the core as a one-cycle Do pulse, waits for valid, routes the result back to the granted requester.
- Timeout guard: a core that never returns valid is converted to an error response.
- Sits between FPU front-end issue logic and core_SQRT.

Parameters:
- WIDTH, 9, mantissa/operand width (matches core s_i/res_o).
- TIMEOUT, 16, max cycles in WAIT before forcing an error response; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0_valid_i  in  1  requester 0 has an op
- req0_op_i  in  1  0 = sqrt, 1 = inverse sqrt
- req0_s_i  in  WIDTH  requester 0 operand
- req0_ready_o  out  1  op accepted this cycle (combinational)
- rsp0_valid_o  out  1  one-cycle response pulse
- rsp0_res_o  out  WIDTH  result
- rsp0_err_o  out  1  timeout error flag
- req1_* / rsp1_*  same set for requester 1
- DoSqrt_o  out  1  to core DoSqrt_i
- DoInvSqrt_o  out  1  to core DoInvSqrt_i
- s_o  out  WIDTH  to core s_i
- res_i  in  WIDTH  from core res_o
- valid_i  in  1  from core valid_o

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, rr pointer=0 (requester 0 favoured), wait counter=0.
- All registered outputs cleared to 0: DoSqrt_o, DoInvSqrt_o, s_o, rsp*_valid_o, rsp*_res_o, rsp*_err_o.
- reqN_ready_o is 0 while rst=1.
- Reset mid-operation abandons the op: no response is issued, and a later core valid_i is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the requester with valid=1; if both are valid, the rr pointer decides.
  - reqN_ready_o=1 combinationally only for the winner, and only in IDLE.
  - On accept, latch op, operand and granted id, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Registered DoSqrt_o=1 (op=0) or DoInvSqrt_o=1 (op=1); s_o=latched operand.
  - Next state WAIT; counter cleared.
- WAIT:
  - Do outputs low; s_o holds the operand.
  - If valid_i=1: capture res_i, err=0, go to RESP.
  - Else increment counter. When counter reaches TIMEOUT-1 with no valid: res=0, err=1, go to RESP.
  - valid_i and the final timeout count in the same cycle: valid wins (err=0).
- RESP (exactly 1 cycle):
  - rspN_valid_o=1 for the granted id only, with res/err.
  - The other requester's rsp outputs stay 0.
  - rr pointer := not(granted id). Next state IDLE.
- valid_i outside WAIT (stray or late) is ignored; no state change.
- Throughput and latency: one op per (core latency L + 3) cycles.
  - Accept at cycle T; Do pulse at T+1.
  - Core valid at T+1+L; rsp pulse at T+2+L.
- Requester may drop valid without being granted; no request is latched unless ready_o was 1.
- Operand and op must be stable only in the accept cycle.

Test Plan:
- Reset: assert rst 2 cycles with both reqs valid -> all outputs 0, ready 0. First grant after reset goes to req0.
- Single sqrt: req0 op=0 s=9'h100 (1.0), core model latency 6 -> DoSqrt_o pulses 1 cycle at T+1 with s_o=9'h100. rsp0_valid_o=1 at T+8, res=9'h100, err=0; rsp1 silent.
- Contention and fairness: both reqs held valid continuously (req0 sqrt 9'h080, req1 invsqrt 9'h100) -> grants alternate 0,1,0,1 over 4 ops. Each response is routed to the correct port; no Do pulse while an op is in flight.
- Timeout: core model never asserts valid, TIMEOUT=16 -> rsp pulse exactly 16 cycles after entering WAIT, res=0, err=1. A subsequent op completes normally.
- Boundary: valid_i arrives on the final timeout cycle -> err=0, res=res_i. Stray valid_i in IDLE -> no response.
- Reset mid-WAIT: rst during WAIT, core valid arrives 2 cycles later -> no rsp pulse; next request is served normally.
